inst_loader: RTL
================

# inst_loader

Boot-time program loader that writes the instruction memory consumed by the core's fetch/decode pipeline. It takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words, and writes them to consecutive instruction-memory word addresses. It screens every word's opcode against the set the main decoder supports, then returns an acknowledge byte to the host through the UART transmitter. It asserts `load_done`, which releases the core from its boot hold.

## Interface
- `ADDR_W`, default 12: instruction-memory word-address width (depth 2**ADDR_W words).
- `ACK_BYTE`, default 8'hAA: byte returned to the host after the load completes.

- `clk`  in  1  single clock; all state is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe per received byte; there is no backpressure.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  transmit request.
- `tx_ready`  in  1  transmitter accepts `tx_data` on a cycle where `tx_valid && tx_ready`.
- `imem_we`  out  1  instruction-memory write enable, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wd`  out  32  instruction word.
- `load_done`  out  1  sticky; high once the acknowledge byte has been accepted.
- `bad_op`  out  1  sticky; at least one loaded word had an unsupported opcode.
- `bad_count`  out  ADDR_W  number of unsupported-opcode words, saturating.

## Operation
- Stream format:
  - 4-byte word count `len`, little-endian: first byte goes to bits 7:0.
  - Then `len` words, 4 bytes each, little-endian.
- States: `S_LEN`, `S_DATA`, `S_ACK`, `S_DONE`. Reset state is `S_LEN`.
- A 2-bit byte index counts bytes within the current 4-byte group. It clears to 0 on entry to `S_LEN` and `S_DATA`, and after every 4th byte.
- `S_LEN`:
  - Shift bytes into `len` on each `rx_valid`.
  - On the 4th byte: if `len == 0`, go to `S_ACK`; otherwise go to `S_DATA` with word index = 0.
- `S_DATA`:
  - Assemble bytes into a word register.
  - On the 4th byte: register `imem_we=1`, `imem_addr` = word index[ADDR_W-1:0], `imem_wd` = assembled word. The word index then increments.
  - When the incremented index equals `len`, go to `S_ACK` on the same edge.
- Depth limit: words with index >= 2**ADDR_W are consumed from the stream but not written (`imem_we` stays low). They are still opcode-checked.
- Opcode check on `imem_wd[6:0]`:
  - Supported set: 0000011, 0100011, 0010111, 0110011, 0110111, 1100011, 0010011, 1100111, 1101111, 1110011.
  - Any other opcode sets `bad_op` and increments `bad_count`, saturating at all-ones.
  - The word is still written.
- `S_ACK`:
  - `tx_valid=1` and `tx_data=ACK_BYTE`, both held stable until `tx_ready`.
  - On handshake, go to `S_DONE`.
- `S_DONE`: `load_done=1`. Stays here until reset.
- `rx_valid` is ignored in `S_ACK` and `S_DONE`.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0`, `imem_we=0`, `imem_addr=0`, `imem_wd=0`, `load_done=0`, `bad_op=0`, `bad_count=0`.
- Reset takes effect immediately, including mid-operation. Partial bytes, partial words and `len` are discarded, and `imem_we` drops without waiting for a clock edge.
- Write latency: `imem_we` is high in the cycle after the edge that samples the word's 4th `rx_valid`. It is high for exactly one cycle unless the next word completes on the following edge.
- Throughput: `rx_valid` on every cycle is supported, giving one write per 4 cycles.
- `bad_op` and `bad_count` update on the same edge that asserts `imem_we` for the offending word.
- `tx_valid`:
  - Rises in the same cycle as the final `imem_we` pulse.
  - For `len == 0`, rises in the cycle after the 4th length byte is sampled.
- `load_done` rises in the cycle after the `tx_valid && tx_ready` cycle, and `tx_valid` falls in that same cycle.
- `imem_addr` and `imem_wd` hold their last values when `imem_we` is low.

## Test plan
- Single word: len=1 (bytes 01 00 00 00), then 93 00 50 00.
  - Expect one `imem_we` pulse with addr 0 and wd 0x00500093.
  - `bad_op=0`; `tx_data=0xAA` with `tx_valid`; `load_done=1` after handshake.
- Empty load: len=0.
  - Expect no `imem_we`.
  - `tx_valid` in the cycle after the 4th byte; `load_done` follows the handshake.
- Back-to-back: len=3, 12 data bytes on consecutive cycles, words 0x00000013, 0x00100093, 0x0000006F.
  - Expect three pulses at addr 0/1/2, four cycles apart, with correct data.
- Illegal opcode: len=2, words 0xFFFFFFFF and 0x00000013.
  - Expect both written.
  - `bad_op=1` and `bad_count=1` from the first pulse onward.
- Ack stall: `tx_ready` held low for 5 cycles, with extra `rx_valid` bytes injected meanwhile.
  - Expect `tx_valid` and `tx_data` stable and no writes.
  - `load_done` rises exactly one cycle after `tx_ready` goes high.
- Reset mid-word: `rstn` pulled low after 2 of 4 data bytes.
  - Expect all outputs at their reset values immediately.
  - A following complete len=1 load writes addr 0 with the correct word.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time program loader: assembles a little-endian length-prefixed byte stream into 32-bit
// instruction words, writes them to instruction memory, screens opcodes and acks the host.
module inst_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              load_done,
  output logic              bad_op,
  output logic [ADDR_W-1:0] bad_count
);

  typedef enum logic [1:0] {StLen, StData, StAck, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       word_idx_q, word_idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic              bad_op_q, bad_op_d;
  logic [ADDR_W-1:0] bad_count_q, bad_count_d;

  logic        rx_take, last_byte, word_done, in_range;
  logic [31:0] next_len, next_word, word_idx_inc;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0010111, 7'b0110011, 7'b0110111,
      7'b1100011, 7'b0010011, 7'b1100111, 7'b1101111, 7'b1110011: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

  assign rx_take      = rx_valid && ((state_q == StLen) || (state_q == StData));
  assign last_byte    = rx_take && (byte_idx_q == 2'd3);
  assign word_done    = last_byte && (state_q == StData);
  assign next_len     = {rx_data, len_q[31:8]};
  assign next_word    = {rx_data, word_q[31:8]};
  assign word_idx_inc = word_idx_q + 32'd1;
  // Words past the memory depth are consumed and screened but never written.
  assign in_range     = (word_idx_q >> ADDR_W) == 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StLen;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLen:   if (last_byte) state_d = (next_len == 32'd0) ? StAck : StData;
      StData:  if (word_done && (word_idx_inc == len_q)) state_d = StAck;
      StAck:   if (tx_ready) state_d = StDone;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    tx_valid  = (state_q == StAck);
    tx_data   = tx_valid ? ACK_BYTE : 8'h00;
    load_done = (state_q == StDone);
  end

  always_comb begin
    byte_idx_d  = rx_take ? byte_idx_q + 2'd1 : byte_idx_q;
    len_d       = (rx_take && (state_q == StLen)) ? next_len : len_q;
    word_d      = (rx_take && (state_q == StData)) ? next_word : word_q;
    word_idx_d  = word_idx_q;
    if (last_byte && (state_q == StLen)) word_idx_d = 32'd0;
    if (word_done) word_idx_d = word_idx_inc;
    we_d        = word_done && in_range;
    addr_d      = we_d ? word_idx_q[ADDR_W-1:0] : addr_q;
    wd_d        = we_d ? next_word : wd_q;
    bad_op_d    = bad_op_q;
    bad_count_d = bad_count_q;
    if (word_done && !op_supported(next_word[6:0])) begin
      bad_op_d = 1'b1;
      if (bad_count_q != {ADDR_W{1'b1}}) begin
        bad_count_d = bad_count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_idx_q  <= 2'd0;
      len_q       <= 32'd0;
      word_q      <= 32'd0;
      word_idx_q  <= 32'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= 32'd0;
      bad_op_q    <= 1'b0;
      bad_count_q <= '0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      len_q       <= len_d;
      word_q      <= word_d;
      word_idx_q  <= word_idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      bad_op_q    <= bad_op_d;
      bad_count_q <= bad_count_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign bad_op    = bad_op_q;
  assign bad_count = bad_count_q;

endmodule
